// File: rtl/seg7_scroller.sv
// Scroll sequencer: software pushes hex nibbles, then the block periodically writes
// an NDIGITS-wide sliding window of the buffer to the 7-segment display's digit register.
`timescale 1ns/1ps

module seg7_scroller #(
    parameter logic [31:0] BASE     = 32'h20,
    parameter logic [31:0] SEG_BASE = 32'h10,
    parameter int          NDIGITS  = 4,
    parameter int          DEPTH    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        m_enable,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_data,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int          IW         = $clog2(DEPTH);
    localparam int          CW         = IW + 1;
    localparam int          KW         = $clog2(DEPTH + NDIGITS) + 1;
    localparam logic [31:0] PERIOD_RST = 32'd25_000_000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t              r_state;
    logic [3:0]          r_buf [DEPTH];
    logic [CW-1:0]       r_count;
    logic [IW-1:0]       r_pos;
    logic [31:0]         r_period;
    logic [31:0]         r_timer;
    logic                r_run;
    logic                r_wrap;
    logic                r_done;
    logic                r_overflow;
    logic                r_m_enable;
    logic [31:0]         r_m_addr;
    logic [31:0]         r_m_data;

    logic                w_sel;
    logic [1:0]          w_off;
    logic                w_wr_ctrl;
    logic                w_wr_period;
    logic                w_wr_push;
    logic                w_wr_clear;
    logic                w_buf_full;
    logic [4*NDIGITS-1:0] w_window;

    // The window is only 4 words, so the low address bits select the register.
    assign w_sel       = enable && rw && (addr >= BASE) && (addr < BASE + 32'd4);
    assign w_off       = addr[1:0] - BASE[1:0];
    assign w_wr_ctrl   = w_sel && (w_off == 2'd0);
    assign w_wr_period = w_sel && (w_off == 2'd1);
    assign w_wr_push   = w_sel && (w_off == 2'd2);
    assign w_wr_clear  = w_sel && (w_off == 2'd3);
    assign w_buf_full  = (r_count == CW'(DEPTH));

    // Digit i (0 = rightmost) shows buffer entry pos + (NDIGITS-1-i).
    always_comb begin : window_mux
        logic [KW-1:0] k;
        logic [KW-1:0] km;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_window = '0;
        k        = '0;
        km       = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            k  = KW'(r_pos) + KW'(NDIGITS - 1 - i);
            km = '0;
            if (r_count != '0) begin
                if (r_wrap) begin
                    km = k % KW'(r_count);
                    w_window[4*i +: 4] = r_buf[km[IW-1:0]];
                end else if (k < KW'(r_count)) begin
                    w_window[4*i +: 4] = r_buf[k[IW-1:0]];
                end
            end
        end
    end

    // NOTE: buffer entries beyond count are never displayed, so the array has no reset.
    always_ff @(posedge clk) begin
        if (reset_n && w_wr_push && !w_buf_full) begin
            r_buf[r_count[IW-1:0]] <= data[3:0];
        end
    end

    // NOTE: clocked state uses <= only, so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_pos      <= '0;
            r_period   <= PERIOD_RST;
            r_timer    <= '0;
            r_run      <= 1'b0;
            r_wrap     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_m_enable <= 1'b0;
            r_m_addr   <= '0;
            r_m_data   <= '0;
        end else begin
            r_m_enable <= 1'b0;
            r_m_addr   <= '0;
            r_m_data   <= '0;

            case (r_state)
                S_IDLE: begin
                    if (r_run && r_count != '0) begin
                        r_state    <= S_EMIT;
                        r_m_enable <= 1'b1;
                        r_m_addr   <= SEG_BASE;
                        r_m_data   <= 32'(w_window);
                    end
                end
                S_EMIT: begin
                    r_timer <= (r_period == '0) ? '0 : r_period - 32'd1;
                    if (r_wrap) begin
                        r_pos   <= (CW'(r_pos) + CW'(1) == r_count) ? '0 : r_pos + 1'b1;
                        r_state <= S_WAIT;
                    end else if (KW'(r_pos) + KW'(NDIGITS) >= KW'(r_count)) begin
                        r_run   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_pos   <= r_pos + 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!r_run) begin
                        r_state <= S_IDLE;
                    end else if (r_timer == '0) begin
                        r_state    <= S_EMIT;
                        r_m_enable <= 1'b1;
                        r_m_addr   <= SEG_BASE;
                        r_m_data   <= 32'(w_window);
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Bus writes land after the FSM so they override it at the same edge.
            if (w_wr_ctrl) begin
                r_run  <= data[0];
                r_wrap <= data[1];
                if (data[0] && !r_run) begin
                    r_done <= 1'b0;
                    if (r_done) begin
                        r_pos <= '0;
                    end
                end
            end
            if (w_wr_period) begin
                r_period <= data;
            end
            if (w_wr_push) begin
                if (w_buf_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_wr_clear) begin
                r_state    <= S_IDLE;
                r_count    <= '0;
                r_pos      <= '0;
                r_run      <= 1'b0;
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
                r_m_enable <= 1'b0;
                r_m_addr   <= '0;
                r_m_data   <= '0;
            end
        end
    end

    assign m_enable = r_m_enable;
    assign m_rw     = r_m_enable;
    assign m_addr   = r_m_addr;
    assign m_data   = r_m_data;
    assign busy     = r_run;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_seg7_scroller.sv
// Directed bench for seg7_scroller: pulses are logged on the falling edge and each
// scenario task compares the log and status outputs against hand-computed values.
`timescale 1ns/1ps

module tb_seg7_scroller;

    localparam logic [31:0] A_CTRL   = 32'h20;
    localparam logic [31:0] A_PERIOD = 32'h21;
    localparam logic [31:0] A_PUSH   = 32'h22;
    localparam logic [31:0] A_CLEAR  = 32'h23;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        m_enable;
    logic        m_rw;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        busy;
    logic        done;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] p_data[$];
    logic [31:0] p_addr[$];
    logic        p_rw[$];
    int          p_cyc[$];

    seg7_scroller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .rw      (rw),
        .addr    (addr),
        .data    (data),
        .m_enable(m_enable),
        .m_rw    (m_rw),
        .m_addr  (m_addr),
        .m_data  (m_data),
        .busy    (busy),
        .done    (done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_enable === 1'b1) begin
            p_data.push_back(m_data);
            p_addr.push_back(m_addr);
            p_rw.push_back(m_rw);
            p_cyc.push_back(cyc);
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        enable = 1'b1;
        rw     = 1'b1;
        addr   = a;
        data   = d;
        @(posedge clk);
        #1;
        enable = 1'b0;
        rw     = 1'b0;
        addr   = '0;
        data   = '0;
    endtask

    task automatic push(input logic [3:0] v);
        wr(A_PUSH, {28'd0, v});
    endtask

    task automatic push_123456();
        for (int i = 1; i <= 6; i++) push(4'(i));
    endtask

    task automatic clr_log();
        p_data.delete();
        p_addr.delete();
        p_rw.delete();
        p_cyc.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        rw      = 1'b0;
        addr    = '0;
        data    = '0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        checks++; if (m_enable !== 1'b0) begin errors++; $display("FAIL reset m_enable: got %b want 0", m_enable); end
        checks++; if (m_rw !== 1'b0) begin errors++; $display("FAIL reset m_rw: got %b want 0", m_rw); end
        checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL reset m_addr: got %h want 0", m_addr); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset m_data: got %h want 0", m_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", overflow); end
    endtask

    task automatic test_nonwrap();
        logic [31:0] exp [3];
        int t;
        exp = '{32'h1234, 32'h2345, 32'h3456};
        push_123456();
        wr(A_PERIOD, 32'd3);
        clr_log();
        wr(A_CTRL, 32'd1);
        t = cyc;
        tick(20);
        checks++; if (p_data.size() != 3) begin errors++; $display("FAIL nonwrap pulse count: got %0d want 3", p_data.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= p_data.size() || p_data[i] !== exp[i] || p_addr[i] !== 32'h10 || p_rw[i] !== 1'b1) begin
                errors++;
                $display("FAIL nonwrap pulse %0d: got data %h addr %h rw %b want data %h addr 10 rw 1",
                         i, (i < p_data.size()) ? p_data[i] : 32'hx, (i < p_addr.size()) ? p_addr[i] : 32'hx,
                         (i < p_rw.size()) ? p_rw[i] : 1'bx, exp[i]);
            end
        end
        checks++; if (p_cyc.size() < 1 || p_cyc[0] != t + 1) begin errors++; $display("FAIL nonwrap first latency: got cycle %0d want %0d", (p_cyc.size() > 0) ? p_cyc[0] : -1, t + 1); end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (i >= p_cyc.size() || p_cyc[i] - p_cyc[i-1] != 4) begin
                errors++;
                $display("FAIL nonwrap spacing %0d: got %0d want 4", i, (i < p_cyc.size()) ? p_cyc[i] - p_cyc[i-1] : -1);
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL nonwrap done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nonwrap busy: got %b want 0", busy); end
        checks++; if (m_addr !== 32'h0 || m_data !== 32'h0) begin errors++; $display("FAIL nonwrap idle bus: got addr %h data %h want 0 0", m_addr, m_data); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [7];
        exp = '{32'h1234, 32'h2345, 32'h3456, 32'h4561, 32'h5612, 32'h6123, 32'h1234};
        wr(A_CLEAR, 32'd0);
        push_123456();
        clr_log();
        wr(A_CTRL, 32'd3);
        tick(27);
        wr(A_CTRL, 32'd0);
        checks++; if (p_data.size() < 7) begin errors++; $display("FAIL wrap pulse count: got %0d want at least 7", p_data.size()); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (i >= p_data.size() || p_data[i] !== exp[i]) begin
                errors++;
                $display("FAIL wrap pulse %0d: got %h want %h", i, (i < p_data.size()) ? p_data[i] : 32'hx, exp[i]);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap stop busy: got %b want 0", busy); end
        tick(6);
        wr(A_CLEAR, 32'd0);
    endtask

    task automatic test_overflow();
        wr(A_PERIOD, 32'd0);
        for (int i = 0; i < 17; i++) push(4'(i));
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow set: got %b want 1", overflow); end
        clr_log();
        wr(A_CTRL, 32'd1);
        tick(40);
        checks++; if (p_data.size() != 13) begin errors++; $display("FAIL overflow count16 pulses: got %0d want 13", p_data.size()); end
        checks++; if (p_data.size() < 1 || p_data[0] !== 32'h0123) begin errors++; $display("FAIL overflow first window: got %h want 0123", (p_data.size() > 0) ? p_data[0] : 32'hx); end
        checks++; if (p_data.size() < 13 || p_data[12] !== 32'hCDEF) begin errors++; $display("FAIL overflow last window: got %h want cdef", (p_data.size() > 12) ? p_data[12] : 32'hx); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow sticky: got %b want 1", overflow); end
        wr(A_CLEAR, 32'd0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow clear: got %b want 0", overflow); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL overflow clear done: got %b want 0", done); end
        clr_log();
        wr(A_CTRL, 32'd1);
        tick(10);
        checks++; if (p_data.size() != 0) begin errors++; $display("FAIL empty run pulses: got %0d want 0", p_data.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty run busy: got %b want 1", busy); end
        wr(A_CLEAR, 32'd0);
    endtask

    task automatic test_short();
        push(4'hA);
        push(4'hB);
        clr_log();
        wr(A_CTRL, 32'd1);
        tick(10);
        checks++; if (p_data.size() != 1) begin errors++; $display("FAIL short pulse count: got %0d want 1", p_data.size()); end
        checks++; if (p_data.size() < 1 || p_data[0] !== 32'hAB00) begin errors++; $display("FAIL short window: got %h want ab00", (p_data.size() > 0) ? p_data[0] : 32'hx); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL short status: got done %b busy %b want 1 0", done, busy); end
        wr(A_CLEAR, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp = '{32'h1234, 32'h2345, 32'h3456};
        push_123456();
        clr_log();
        wr(A_CTRL, 32'd3);
        tick(5);
        checks++; if (m_enable !== 1'b1) begin errors++; $display("FAIL p0 in pulse: got m_enable %b want 1", m_enable); end
        wr(A_CTRL, 32'd0);
        tick(10);
        checks++; if (p_data.size() != 3) begin errors++; $display("FAIL p0 stop count: got %0d want 3", p_data.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= p_data.size() || p_data[i] !== exp[i]) begin
                errors++;
                $display("FAIL p0 pulse %0d: got %h want %h", i, (i < p_data.size()) ? p_data[i] : 32'hx, exp[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (i >= p_cyc.size() || p_cyc[i] - p_cyc[i-1] != 2) begin
                errors++;
                $display("FAIL p0 spacing %0d: got %0d want 2", i, (i < p_cyc.size()) ? p_cyc[i] - p_cyc[i-1] : -1);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL p0 stop busy: got %b want 0", busy); end
        clr_log();
        wr(A_CTRL, 32'd3);
        tick(4);
        checks++; if (p_data.size() < 1 || p_data[0] !== 32'h4561) begin errors++; $display("FAIL resume first: got %h want 4561", (p_data.size() > 0) ? p_data[0] : 32'hx); end
        checks++; if (p_data.size() < 2 || p_data[1] !== 32'h5612) begin errors++; $display("FAIL resume second: got %h want 5612", (p_data.size() > 1) ? p_data[1] : 32'hx); end
        wr(A_CTRL, 32'd0);
        tick(4);
        wr(A_CLEAR, 32'd0);
    endtask

    task automatic test_reset_mid();
        push_123456();
        wr(A_PERIOD, 32'd5);
        clr_log();
        wr(A_CTRL, 32'd3);
        tick(3);
        reset_n = 1'b0;
        tick(1);
        checks++; if (m_enable !== 1'b0 || m_rw !== 1'b0) begin errors++; $display("FAIL midreset strobe: got en %b rw %b want 0 0", m_enable, m_rw); end
        checks++; if (m_addr !== 32'h0 || m_data !== 32'h0) begin errors++; $display("FAIL midreset bus: got addr %h data %h want 0 0", m_addr, m_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midreset status: got %b%b%b want 000", busy, done, overflow); end
        reset_n = 1'b1;
        clr_log();
        tick(20);
        checks++; if (p_data.size() != 0) begin errors++; $display("FAIL midreset pulses: got %0d want 0", p_data.size()); end
        for (int i = 1; i <= 5; i++) push(4'(i));
        clr_log();
        wr(A_CTRL, 32'd1);
        tick(1000);
        checks++; if (p_data.size() != 1) begin errors++; $display("FAIL default period spacing: got %0d pulses want 1", p_data.size()); end
        checks++; if (p_data.size() < 1 || p_data[0] !== 32'h1234) begin errors++; $display("FAIL default period first: got %h want 1234", (p_data.size() > 0) ? p_data[0] : 32'hx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL default period busy: got %b want 1", busy); end
        wr(A_CLEAR, 32'd0);
    endtask

    initial begin
        test_reset();
        test_nonwrap();
        test_wrap();
        test_overflow();
        test_short();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
